up_core: RTL

Parametrised, self-sequenced successor to the Máquina Sencilla datapath. It combines the datapath (IR, PC, A, B, SP, zero flag, ALU) with an integrated control FSM, so no external control unit is needed. Address and data widths are configurable. It adds SUB, CALL/RET through a memory-resident stack, ready/valid I/O handshakes and HALT. It drives an external single-port RAM (combinational read, write on clock edge) and one addressed I/O channel.

---
 rtl/up_core.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/up_core.sv
// up_core: self-sequenced Maquina Sencilla core with SUB, CALL/RET stack, ready/valid I/O and HALT.
// Optional stack fault detection is enabled by defining UP_STACK_GUARD_EN.
module up_core #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] io_port,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fz,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic              err
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_LOAD_A = 4'd1;
  localparam logic [3:0] S_LOAD_B = 4'd2;
  localparam logic [3:0] S_WRITE  = 4'd3;
  localparam logic [3:0] S_BRANCH = 4'd4;
  localparam logic [3:0] S_IO_IN  = 4'd5;
  localparam logic [3:0] S_IO_OUT = 4'd6;
  localparam logic [3:0] S_PUSH   = 4'd7;
  localparam logic [3:0] S_POP    = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;

  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_IN   = 4'd5;
  localparam logic [3:0] OP_OUT  = 4'd6;
  localparam logic [3:0] OP_CALL = 4'd7;
  localparam logic [3:0] OP_RET  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  if (DATA_W < 4 + 2*ADDR_W) begin : g_bad_width
    $error("up_core: DATA_W must be at least 4 + 2*ADDR_W");
  end
  if (STACK_DEPTH < 1 || STACK_DEPTH >= 2**ADDR_W) begin : g_bad_depth
    $error("up_core: STACK_DEPTH must be in 1 .. 2**ADDR_W-1");
  end

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] f_fld;
  logic [ADDR_W-1:0] d_fld;
  logic [3:0]        cop;
  logic [3:0]        fetch_cop;
  logic              stack_fault;

  assign cop       = ir[DATA_W-1 -: 4];
  assign f_fld     = ir[2*ADDR_W-1:ADDR_W];
  assign d_fld     = ir[ADDR_W-1:0];
  assign fetch_cop = mem_rdata[DATA_W-1 -: 4];
  // CMP shares the subtract path; only the write enable differs.
  assign alu       = (cop == OP_ADD) ? (b + a) : (b - a);

  assign io_port  = f_fld;
  assign out_data = a;
  assign halted   = (state == S_HALT);
  assign pc_dbg   = pc;

`ifdef UP_STACK_GUARD_EN
  localparam logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'((2**ADDR_W) - 1 - STACK_DEPTH);

  assign stack_fault = ((state == S_PUSH) && (sp == SP_LIMIT)) ||
                       ((state == S_POP)  && (sp == {ADDR_W{1'b1}}));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (stack_fault) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  assign stack_fault = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        case (fetch_cop)
          OP_MOV, OP_ADD, OP_SUB, OP_CMP, OP_OUT: state_nxt = S_LOAD_A;
          OP_BEQ:  state_nxt = S_BRANCH;
          OP_IN:   state_nxt = S_IO_IN;
          OP_CALL: state_nxt = S_PUSH;
          OP_RET:  state_nxt = S_POP;
          OP_HALT: state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_LOAD_A: begin
        if (cop == OP_MOV) begin
          state_nxt = S_WRITE;
        end else if (cop == OP_OUT) begin
          state_nxt = S_IO_OUT;
        end else begin
          state_nxt = S_LOAD_B;
        end
      end
      S_LOAD_B: state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_IO_IN:  state_nxt = in_valid ? S_FETCH : S_IO_IN;
      S_IO_OUT: state_nxt = out_ready ? S_FETCH : S_IO_OUT;
      S_PUSH:   state_nxt = stack_fault ? S_HALT : S_FETCH;
      S_POP:    state_nxt = stack_fault ? S_HALT : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_FETCH:  mem_addr = pc;
      S_LOAD_A: mem_addr = f_fld;
      S_LOAD_B: mem_addr = d_fld;
      S_WRITE: begin
        mem_addr  = d_fld;
        mem_wdata = (cop == OP_MOV) ? a : alu;
        mem_we    = (cop != OP_CMP);
      end
      S_IO_IN: begin
        in_ready  = 1'b1;
        mem_addr  = d_fld;
        mem_wdata = in_data;
        mem_we    = in_valid;
      end
      S_IO_OUT: out_valid = 1'b1;
      S_PUSH: begin
        mem_addr  = sp;
        mem_wdata = {{(DATA_W-ADDR_W){1'b0}}, pc};
        mem_we    = !stack_fault;
      end
      S_POP:    mem_addr = sp + ADDR_W'(1);
      default:  mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc    <= '0;
      sp    <= '1;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      fz    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        S_LOAD_A: a <= mem_rdata;
        S_LOAD_B: b <= mem_rdata;
        S_WRITE: begin
          if (cop != OP_MOV) begin
            fz <= (alu == '0);
          end
        end
        S_BRANCH: begin
          if (fz) begin
            pc <= d_fld;
          end
        end
        S_PUSH: begin
          if (!stack_fault) begin
            sp <= sp - ADDR_W'(1);
            pc <= d_fld;
          end
        end
        S_POP: begin
          if (!stack_fault) begin
            sp <= sp + ADDR_W'(1);
            pc <= mem_rdata[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
